// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the coin-return dispenser: widths, coin values, FSM states.
// Latency: n/a (types only). Backpressure: n/a.
package change_dispenser_pkg;

  localparam int NUM_COINS  = 3;
  localparam int TOTAL_BITS = 31;
  localparam int INV_BITS   = 8;
  localparam int INIT_STOCK = 10;

  typedef logic [TOTAL_BITS-1:0] amount_t;
  typedef logic [INV_BITS-1:0]   stock_t;
  typedef logic [NUM_COINS-1:0]  coin_vec_t;
  typedef stock_t  [NUM_COINS-1:0] stock_vec_t;
  typedef amount_t [NUM_COINS-1:0] coin_vals_t;

  localparam amount_t COIN_VAL0 = amount_t'(100);
  localparam amount_t COIN_VAL1 = amount_t'(500);
  localparam amount_t COIN_VAL2 = amount_t'(1000);

  // Index 0 is the smallest denomination.
  localparam coin_vals_t COIN_VALS = {COIN_VAL2, COIN_VAL1, COIN_VAL0};

  localparam stock_t STOCK_MAX = '1;

  typedef enum logic [1:0] {
    DISP_IDLE     = 2'd0,
    DISP_SELECT   = 2'd1,
    DISP_DISPENSE = 2'd2,
    DISP_DONE     = 2'd3
  } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Request, deposit and hopper handshake bundle of the dispenser.
// Latency: n/a (wires only). Backpressure: hopper ready throttles coin valid.
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic      i_return_req;
  amount_t   i_return_amount;
  coin_vec_t i_input_coin;
  logic      i_coin_ready;
  logic      o_coin_valid;
  coin_vec_t o_coin_sel;
  logic      o_busy;
  logic      o_done;
  amount_t   o_shortfall;

  modport master (
    output i_return_req, i_return_amount, i_input_coin, i_coin_ready,
    input  o_coin_valid, o_coin_sel, o_busy, o_done, o_shortfall
  );

  modport slave (
    input  i_return_req, i_return_amount, i_input_coin, i_coin_ready,
    output o_coin_valid, o_coin_sel, o_busy, o_done, o_shortfall
  );

endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Greedy selector: largest in-stock denomination not exceeding the remaining amount.
// Latency: combinational. Backpressure: none.
module change_dispenser_coin_picker
  import change_dispenser_pkg::*;
(
  input  amount_t    remaining,
  input  stock_vec_t stock,
  input  coin_vals_t coin_vals,
  output logic       found,
  output coin_vec_t  sel
);

  // Ascending scan, so the last eligible index (the largest value) wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if ((stock[k] != '0) && (coin_vals[k] <= remaining)) begin
        found  = 1'b1;
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a return amount one coin per valid/ready transfer, tracking per-denomination stock.
// Latency: first coin 2 cycles after request, then ready wait + 2 per coin. Valid holds until ready.
module change_dispenser
  import change_dispenser_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  change_dispenser_if.slave bus
);

  disp_state_e state_q, state_d;
  amount_t     remaining_q, remaining_d;
  amount_t     shortfall_q, shortfall_d;
  amount_t     sel_val;
  stock_vec_t  stock_q, stock_d;
  coin_vec_t   sel_q, sel_d;
  coin_vec_t   pick_sel;
  coin_vec_t   disp_vec;
  logic        valid_q, valid_d;
  logic        pick_found;
  logic        xfer;

  change_dispenser_coin_picker u_picker (
    .remaining (remaining_q),
    .stock     (stock_q),
    .coin_vals (COIN_VALS),
    .found     (pick_found),
    .sel       (pick_sel)
  );

  assign xfer     = (state_q == DISP_DISPENSE) && valid_q && bus.i_coin_ready;
  assign disp_vec = xfer ? sel_q : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    sel_val     = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (sel_q[k]) sel_val = sel_val | COIN_VALS[k];
    end
    case (state_q)
      DISP_IDLE: begin
        if (bus.i_return_req) begin
          remaining_d = bus.i_return_amount;
          shortfall_d = '0;
          state_d     = DISP_SELECT;
        end
      end
      DISP_SELECT: begin
        if (pick_found) begin
          sel_d   = pick_sel;
          valid_d = 1'b1;
          state_d = DISP_DISPENSE;
        end else begin
          shortfall_d = remaining_q;
          state_d     = DISP_DONE;
        end
      end
      DISP_DISPENSE: begin
        // Picker guaranteed value <= remaining, so this cannot underflow.
        if (xfer) begin
          remaining_d = remaining_q - sel_val;
          valid_d     = 1'b0;
          sel_d       = '0;
          state_d     = DISP_SELECT;
        end
      end
      DISP_DONE: state_d = DISP_IDLE;
      default:   state_d = DISP_IDLE;
    endcase
  end

  // Deposit and payout of the same denomination in one cycle cancel out.
  always_comb begin
    stock_d = stock_q;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (bus.i_input_coin[k] && !disp_vec[k]) begin
        if (stock_q[k] != STOCK_MAX) stock_d[k] = stock_q[k] + stock_t'(1);
      end else if (!bus.i_input_coin[k] && disp_vec[k]) begin
        if (stock_q[k] != '0) stock_d[k] = stock_q[k] - stock_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DISP_IDLE;
      remaining_q <= '0;
      shortfall_q <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      stock_q     <= {NUM_COINS{stock_t'(INIT_STOCK)}};
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      stock_q     <= stock_d;
    end
  end

  assign bus.o_coin_valid = valid_q;
  assign bus.o_coin_sel   = sel_q;
  assign bus.o_busy       = (state_q != DISP_IDLE);
  assign bus.o_done       = (state_q == DISP_DONE);
  assign bus.o_shortfall  = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized requests checked
// against a closed-form greedy payout model with per-denomination stock.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int coin_val [3] = '{100, 500, 1000};
  int model_stock [3];

  logic [255:0] exp_sig, obs_sig;
  int exp_cnt, exp_short;
  int obs_cnt, obs_lat, obs_first, obs_hs_err, obs_busy_err;
  amount_t obs_short;

  // Greedy payout in closed form: take as many of each denomination as fit, largest first.
  task automatic plan(input int amount);
    int rem, n;
    logic [2:0] oh;
    rem = amount; exp_sig = '0; exp_cnt = 0;
    for (int k = 2; k >= 0; k--) begin
      n = rem / coin_val[k];
      if (n > model_stock[k]) n = model_stock[k];
      model_stock[k] -= n;
      rem -= n * coin_val[k];
      exp_cnt += n;
      oh = 3'b001 << k;
      for (int i = 0; i < n; i++) exp_sig = {exp_sig[252:0], oh};
    end
    exp_short = rem;
  endtask

  task automatic deposit_model(input logic [2:0] coins);
    for (int k = 0; k < 3; k++)
      if (coins[k] && model_stock[k] < 255) model_stock[k]++;
  endtask

  // Drives one request and records what the hopper side observed; callers judge the results.
  task automatic do_request(input int amount, input int rdy_pct);
    logic pv, pr;
    logic [2:0] ps;
    obs_sig = '0; obs_cnt = 0; obs_short = '1; obs_lat = -1; obs_first = -1;
    obs_hs_err = 0; obs_busy_err = 0;
    @(negedge clk);
    bus.i_return_amount = amount_t'(amount);
    bus.i_return_req = 1'b1;
    @(negedge clk);
    bus.i_return_req = 1'b0;
    pv = 1'b0; pr = 1'b0; ps = '0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      if (pv && !pr && (bus.o_coin_valid !== 1'b1 || bus.o_coin_sel !== ps)) obs_hs_err++;
      if (bus.o_busy !== 1'b1) obs_busy_err++;
      if (bus.o_done === 1'b1) begin
        obs_lat = cyc;
        obs_short = bus.o_shortfall;
        break;
      end
      if (bus.o_coin_valid === 1'b1 && obs_first < 0) obs_first = cyc;
      bus.i_coin_ready = (int'($urandom_range(99)) < rdy_pct);
      if (bus.o_coin_valid === 1'b1 && bus.i_coin_ready) begin
        obs_sig = {obs_sig[252:0], bus.o_coin_sel};
        obs_cnt++;
      end
      pv = bus.o_coin_valid; pr = bus.i_coin_ready; ps = bus.o_coin_sel;
      @(negedge clk);
    end
    bus.i_coin_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.o_coin_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_coin_valid); end
    n_vec++; if (bus.o_coin_sel !== 3'b000) begin n_err++; $display("FAIL reset_sel got %b want 000", bus.o_coin_sel); end
    n_vec++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b%b want 00", bus.o_busy, bus.o_done); end
    n_vec++; if (bus.o_shortfall !== '0) begin n_err++; $display("FAIL reset_shortfall got %0d want 0", bus.o_shortfall); end
    for (int k = 0; k < 3; k++) begin
      model_stock[k] = 10;
      n_vec++; if (dut.stock_q[k] !== 8'd10) begin n_err++; $display("FAIL reset_stock%0d got %0d want 10", k, dut.stock_q[k]); end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    plan(1600);
    do_request(1600, 100);
    n_vec++; if (obs_sig !== 256'h111 || obs_sig !== exp_sig) begin n_err++; $display("FAIL basic_coins got %h want %h", obs_sig, exp_sig); end
    n_vec++; if (obs_lat !== 8) begin n_err++; $display("FAIL basic_done_latency got %0d want 8", obs_lat); end
    n_vec++; if (obs_first !== 2) begin n_err++; $display("FAIL basic_first_valid got %0d want 2", obs_first); end
    n_vec++; if (obs_short !== '0) begin n_err++; $display("FAIL basic_shortfall got %0d want 0", obs_short); end
    n_vec++; if (obs_busy_err !== 0) begin n_err++; $display("FAIL basic_busy got %0d drops want 0", obs_busy_err); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (dut.stock_q[k] !== 8'd9) begin n_err++; $display("FAIL basic_stock%0d got %0d want 9", k, dut.stock_q[k]); end
    end
  endtask

  task automatic test_stall();
    int seen_done;
    plan(1000);
    @(negedge clk);
    bus.i_return_amount = amount_t'(1000); bus.i_return_req = 1'b1;
    @(negedge clk); bus.i_return_req = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.o_coin_valid !== 1'b1 || bus.o_coin_sel !== 3'b100) begin n_err++; $display("FAIL stall_present got v=%b sel=%b want v=1 sel=100", bus.o_coin_valid, bus.o_coin_sel); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (bus.o_coin_valid !== 1'b1 || bus.o_coin_sel !== 3'b100) begin n_err++; $display("FAIL stall_hold%0d got v=%b sel=%b want v=1 sel=100", i, bus.o_coin_valid, bus.o_coin_sel); end
    end
    bus.i_coin_ready = 1'b1;
    @(negedge clk); bus.i_coin_ready = 1'b0;
    n_vec++; if (bus.o_coin_valid !== 1'b0) begin n_err++; $display("FAIL stall_transfer got v=%b want 0", bus.o_coin_valid); end
    seen_done = 0;
    for (int i = 0; i < 10 && seen_done == 0; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) seen_done = 1;
    end
    n_vec++; if (seen_done !== 1 || bus.o_shortfall !== '0) begin n_err++; $display("FAIL stall_done got done=%0d short=%0d want 1/0", seen_done, bus.o_shortfall); end
    n_vec++; if (dut.stock_q[2] !== 8'(model_stock[2])) begin n_err++; $display("FAIL stall_stock2 got %0d want %0d", dut.stock_q[2], model_stock[2]); end
  endtask

  task automatic test_deposit_busy();
    int seen_done, extra;
    plan(500);
    deposit_model(3'b010);
    @(negedge clk);
    bus.i_return_amount = amount_t'(500); bus.i_return_req = 1'b1;
    @(negedge clk);
    bus.i_return_amount = amount_t'(1000); bus.i_return_req = 1'b1;
    @(negedge clk); bus.i_return_req = 1'b0;
    n_vec++; if (bus.o_coin_valid !== 1'b1 || bus.o_coin_sel !== 3'b010) begin n_err++; $display("FAIL depbusy_present got v=%b sel=%b want v=1 sel=010", bus.o_coin_valid, bus.o_coin_sel); end
    bus.i_coin_ready = 1'b1; bus.i_input_coin = 3'b010;
    @(negedge clk); bus.i_coin_ready = 1'b0; bus.i_input_coin = 3'b000;
    n_vec++; if (dut.stock_q[1] !== 8'(model_stock[1])) begin n_err++; $display("FAIL depbusy_stock1 got %0d want %0d", dut.stock_q[1], model_stock[1]); end
    seen_done = 0;
    for (int i = 0; i < 10 && seen_done == 0; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) seen_done = 1;
    end
    n_vec++; if (seen_done !== 1 || bus.o_shortfall !== '0) begin n_err++; $display("FAIL depbusy_done got done=%0d short=%0d want 1/0", seen_done, bus.o_shortfall); end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_coin_valid !== 1'b0 || bus.o_busy !== 1'b0) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL depbusy_ignored got %0d active cycles want 0", extra); end
  endtask

  task automatic test_deposits();
    @(negedge clk); bus.i_input_coin = 3'b111; deposit_model(3'b111);
    @(negedge clk); bus.i_input_coin = 3'b000;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (dut.stock_q[k] !== 8'(model_stock[k])) begin n_err++; $display("FAIL multi_dep_stock%0d got %0d want %0d", k, dut.stock_q[k], model_stock[k]); end
    end
    bus.i_input_coin = 3'b001;
    repeat (260) begin
      deposit_model(3'b001);
      @(negedge clk);
    end
    bus.i_input_coin = 3'b000;
    @(negedge clk);
    n_vec++; if (dut.stock_q[0] !== 8'd255 || model_stock[0] != 255) begin n_err++; $display("FAIL sat_stock0 got %0d want 255", dut.stock_q[0]); end
  endtask

  task automatic test_random();
    int amount, pct, nd;
    logic [2:0] coins;
    for (int it = 0; it < 30; it++) begin
      nd = $urandom_range(3);
      for (int d = 0; d < nd; d++) begin
        @(negedge clk);
        coins = 3'($urandom_range(7));
        bus.i_input_coin = coins;
        deposit_model(coins);
      end
      @(negedge clk); bus.i_input_coin = 3'b000;
      amount = $urandom_range(45) * 100;
      if ($urandom_range(3) == 0) amount += $urandom_range(1, 99);
      pct = $urandom_range(30, 100);
      if (it % 4 == 0) pct = 100;
      plan(amount);
      do_request(amount, pct);
      n_vec++; if (obs_lat < 0) begin n_err++; $display("FAIL rnd%0d_timeout got no done want done", it); end
      n_vec++; if (obs_sig !== exp_sig || obs_cnt != exp_cnt) begin n_err++; $display("FAIL rnd%0d_coins amt=%0d got %0d:%h want %0d:%h", it, amount, obs_cnt, obs_sig, exp_cnt, exp_sig); end
      n_vec++; if (obs_short !== amount_t'(exp_short)) begin n_err++; $display("FAIL rnd%0d_shortfall got %0d want %0d", it, obs_short, exp_short); end
      n_vec++; if (obs_hs_err != 0 || obs_busy_err != 0) begin n_err++; $display("FAIL rnd%0d_protocol got hs=%0d busy=%0d want 0/0", it, obs_hs_err, obs_busy_err); end
      if (pct == 100) begin
        n_vec++; if (obs_lat != 2 + 2 * exp_cnt) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", it, obs_lat, 2 + 2 * exp_cnt); end
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++; if (dut.stock_q[k] !== 8'(model_stock[k])) begin n_err++; $display("FAIL rnd%0d_stock%0d got %0d want %0d", it, k, dut.stock_q[k], model_stock[k]); end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_return_amount = amount_t'(1000); bus.i_return_req = 1'b1;
    @(negedge clk); bus.i_return_req = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.o_coin_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b want 1", bus.o_coin_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (bus.o_coin_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin n_err++; $display("FAIL arst_outputs got v=%b b=%b d=%b want 000", bus.o_coin_valid, bus.o_busy, bus.o_done); end
    for (int k = 0; k < 3; k++) begin
      model_stock[k] = 10;
      n_vec++; if (dut.stock_q[k] !== 8'd10) begin n_err++; $display("FAIL arst_stock%0d got %0d want 10", k, dut.stock_q[k]); end
    end
    @(negedge clk); reset_n = 1'b1;
    plan(100);
    do_request(100, 100);
    n_vec++; if (obs_sig !== 256'h1 || obs_short !== '0 || obs_lat != 4) begin n_err++; $display("FAIL arst_req100 got sig=%h short=%0d lat=%0d want 1/0/4", obs_sig, obs_short, obs_lat); end
    plan(0);
    do_request(0, 100);
    n_vec++; if (obs_lat != 2 || obs_short !== '0 || obs_cnt != 0) begin n_err++; $display("FAIL zero_amount got lat=%0d short=%0d coins=%0d want 2/0/0", obs_lat, obs_short, obs_cnt); end
  endtask

  task automatic test_depletion();
    plan(10000); do_request(10000, 100);
    n_vec++; if (obs_cnt != 10 || obs_sig !== exp_sig || dut.stock_q[2] !== 8'd0) begin n_err++; $display("FAIL deplete2 got cnt=%0d stock2=%0d want 10/0", obs_cnt, dut.stock_q[2]); end
    plan(2000); do_request(2000, 70);
    n_vec++; if (obs_sig !== 256'h492 || obs_short !== '0) begin n_err++; $display("FAIL no1000_coins got %h short=%0d want 492/0", obs_sig, obs_short); end
    n_vec++; if (dut.stock_q[1] !== 8'd6) begin n_err++; $display("FAIL no1000_stock1 got %0d want 6", dut.stock_q[1]); end
    plan(3000); do_request(3000, 100);
    plan(700); do_request(700, 100);
    n_vec++; if (dut.stock_q[1] !== 8'd0 || dut.stock_q[0] !== 8'd2) begin n_err++; $display("FAIL deplete_stock got s1=%0d s0=%0d want 0/2", dut.stock_q[1], dut.stock_q[0]); end
    plan(700); do_request(700, 100);
    n_vec++; if (obs_sig !== 256'h9 || obs_sig !== exp_sig) begin n_err++; $display("FAIL short_coins got %h want 9", obs_sig); end
    n_vec++; if (obs_short !== amount_t'(500) || obs_lat != 6) begin n_err++; $display("FAIL short_amount got %0d lat=%0d want 500/6", obs_short, obs_lat); end
  endtask

  initial begin
    bus.i_return_req = 1'b0;
    bus.i_return_amount = '0;
    bus.i_input_coin = '0;
    bus.i_coin_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_deposit_busy();
    test_deposits();
    test_random();
    test_async_reset();
    test_depletion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
